// File: rtl/f1_pkg.sv
// Shared types and constants for the F1 start-light sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package f1_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        HOLD  = 2'd2
    } state_t;

    localparam logic [6:0] LFSR_SEED = 7'h01;
    localparam int         NUM_LAMPS = 8;

endpackage

// File: rtl/f1_lfsr.sv
// Free-running Fibonacci LFSR (taps on the two top bits, x^7+x^6+1 at WIDTH=7).
// Latency: value advances once per clk out of reset.
// Backpressure: none; never stalls.
module f1_lfsr #(
    parameter int               WIDTH = 7,
    parameter logic [WIDTH-1:0] SEED  = 1
) (
    input  logic             clk,
    input  logic             rst,
    output logic [WIDTH-1:0] value
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            value <= SEED;
        end else begin
            value <= {value[WIDTH-2:0], value[WIDTH-1] ^ value[WIDTH-2]};
        end
    end

endmodule

// File: rtl/f1_light_sequencer.sv
// F1 start-light sequencer: 8 lamps one per tick, random hold, then dark + done pulse.
// Latency: first lamp TICK_CYCLES cycles after COUNT entry; all outputs registered.
// Backpressure: none; trigger while busy is dropped. Optional F1_REACTION_TIMER_EN adds a reaction timer.
module f1_light_sequencer
    import f1_pkg::*;
#(
    parameter int TICK_CYCLES    = 24,
    parameter int LFSR_WIDTH     = 7,
    parameter int MIN_HOLD_TICKS = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 trigger,
    input  logic                 abort,
    output logic [NUM_LAMPS:1]   data_out,
    output logic                 busy,
    output logic                 done,
    input  logic                 react,
    output logic [15:0]          react_time,
    output logic                 react_valid
);

    localparam int TW = (TICK_CYCLES > 2) ? $clog2(TICK_CYCLES) : 1;

    state_t                state;
    logic [TW-1:0]         tick_cnt;
    logic [7:0]            hold_cnt;
    logic [LFSR_WIDTH-1:0] lfsr_val;
    logic                  tick;
    logic                  start;
    logic                  seq_end;

    f1_lfsr #(
        .WIDTH (LFSR_WIDTH),
        .SEED  (LFSR_WIDTH'(LFSR_SEED))
    ) u_lfsr (
        .clk   (clk),
        .rst   (rst),
        .value (lfsr_val)
    );

    assign tick    = (tick_cnt == TW'(TICK_CYCLES - 1));
    assign start   = (state == IDLE) && trigger && !abort;
    assign seq_end = (state == HOLD) && !abort && tick && (hold_cnt == 8'd1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            data_out <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            tick_cnt <= '0;
            hold_cnt <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    data_out <= '0;
                    tick_cnt <= '0;
                    if (start) begin
                        state <= COUNT;
                        busy  <= 1'b1;
                    end
                end
                COUNT: begin
                    if (abort) begin
                        state    <= IDLE;
                        data_out <= '0;
                        busy     <= 1'b0;
                        tick_cnt <= '0;
                    end else begin
                        tick_cnt <= tick ? '0 : tick_cnt + TW'(1);
                        if (tick) begin
                            data_out <= {data_out[NUM_LAMPS-1:1], 1'b1};
                            // Lamp 7 already lit means this tick completes the strip.
                            if (data_out[NUM_LAMPS-1]) begin
                                hold_cnt <= 8'(lfsr_val) + 8'(MIN_HOLD_TICKS);
                                state    <= HOLD;
                            end
                        end
                    end
                end
                HOLD: begin
                    if (abort) begin
                        state    <= IDLE;
                        data_out <= '0;
                        busy     <= 1'b0;
                        tick_cnt <= '0;
                    end else begin
                        tick_cnt <= tick ? '0 : tick_cnt + TW'(1);
                        if (seq_end) begin
                            data_out <= '0;
                            done     <= 1'b1;
                            busy     <= 1'b0;
                            state    <= IDLE;
                        end else if (tick) begin
                            hold_cnt <= hold_cnt - 8'd1;
                        end
                    end
                end
                default: begin
                    state    <= IDLE;
                    data_out <= '0;
                    busy     <= 1'b0;
                    tick_cnt <= '0;
                end
            endcase
        end
    end

`ifdef F1_REACTION_TIMER_EN
    logic [15:0] rt_cnt;
    logic        rt_armed;
    logic        jump;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rt_cnt      <= '0;
            rt_armed    <= 1'b0;
            jump        <= 1'b0;
            react_time  <= '0;
            react_valid <= 1'b0;
        end else begin
            react_valid <= 1'b0;
            if (rt_armed && rt_cnt != 16'hFFFF) begin
                rt_cnt <= rt_cnt + 16'd1;
            end
            if (seq_end) begin
                rt_cnt <= '0;
                jump   <= 1'b0;
                // A press before the lamps went dark is a jump start.
                if (jump || react) begin
                    react_time  <= 16'hFFFF;
                    react_valid <= 1'b1;
                    rt_armed    <= 1'b0;
                end else begin
                    rt_armed <= 1'b1;
                end
            end else if (start) begin
                rt_armed <= 1'b0;
                jump     <= 1'b0;
            end else if (busy && abort) begin
                jump <= 1'b0;
            end else if (busy && react) begin
                jump <= 1'b1;
            end else if (rt_armed && react) begin
                react_time  <= rt_cnt;
                react_valid <= 1'b1;
                rt_armed    <= 1'b0;
            end
        end
    end
`else
    logic unused_react;
    assign unused_react = react;
    assign react_time   = '0;
    assign react_valid  = 1'b0;
`endif

endmodule

// File: tb/tb_f1_light_sequencer.sv
// Self-checking bench for f1_light_sequencer (TICK_CYCLES=4): vector table, corner sequences, random run vs model.
// Reaction-timer checks are compiled in when F1_REACTION_TIMER_EN is defined.
module tb_f1_light_sequencer;

    localparam int T    = 4;
    localparam int MINH = 1;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        trigger = 1'b0;
    logic        abort = 1'b0;
    logic        react = 1'b0;
    logic [8:1]  data_out;
    logic        busy;
    logic        done;
    logic [15:0] react_time;
    logic        react_valid;

    int total = 0;
    int bad   = 0;

    // Reference model state: cycles since reset release and the active sequence.
    int ncyc     = 0;
    bit m_active = 1'b0;
    int m_s      = 0;
    int m_h      = 0;

    typedef struct {
        logic       trg;
        logic       abt;
        int         n;
        logic [7:0] d;
        logic       b;
        logic       dn;
    } vec_t;

    vec_t vecs[11];

    f1_light_sequencer #(
        .TICK_CYCLES    (T),
        .LFSR_WIDTH     (7),
        .MIN_HOLD_TICKS (MINH)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .trigger     (trigger),
        .abort       (abort),
        .data_out    (data_out),
        .busy        (busy),
        .done        (done),
        .react       (react),
        .react_time  (react_time),
        .react_valid (react_valid)
    );

    always #5 clk = ~clk;

    // LFSR value n cycles after reset release; the sequence repeats every 127 steps.
    function automatic int lfsr_at(input int n);
        int v = 1;
        for (int i = 0; i < n % 127; i++) begin
            v = ((v << 1) & 127) | (((v >> 6) ^ (v >> 5)) & 1);
        end
        return v;
    endfunction

    // Expected outputs in cycle c from the sequence timeline.
    function automatic void model_out(input int c, output logic [7:0] d, output logic b, output logic dn);
        int rel;
        int endr;
        int n;
        d  = '0;
        b  = 1'b0;
        dn = 1'b0;
        if (m_active) begin
            rel  = c - m_s;
            endr = 1 + 8 * T + m_h * T;
            if (rel >= 1 && rel < endr) begin
                b = 1'b1;
                n = (rel - 1) / T;
                if (n > 8) n = 8;
                d = 8'((1 << n) - 1);
            end else if (rel == endr) begin
                dn = 1'b1;
            end
        end
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cycle=%0d got=%0h want=%0h", name, ncyc, act, exp);
        end
    endtask

    task automatic step(input logic trg, input logic abt, input logic rct);
        logic [7:0] d;
        logic       b;
        logic       dn;
        trigger = trg;
        abort   = abt;
        react   = rct;
        model_out(ncyc, d, b, dn);
        @(posedge clk);
        #1;
        if (b && abt) begin
            m_active = 1'b0;
        end else if (!b && trg && !abt) begin
            m_active = 1'b1;
            m_s      = ncyc;
            m_h      = lfsr_at(ncyc + 8 * T) + MINH;
        end
        ncyc++;
        model_out(ncyc, d, b, dn);
        chk("model_data", data_out, d);
        chk("model_busy", busy, b);
        chk("model_done", done, dn);
`ifndef F1_REACTION_TIMER_EN
        chk("react_time_off", react_time, 0);
        chk("react_valid_off", react_valid, 0);
`endif
    endtask

    task automatic run_until_data(input logic trg, input logic [7:0] target, input int max, input string name);
        int i = 0;
        while (data_out !== target && i < max) begin
            step(trg, 1'b0, 1'b0);
            i++;
        end
        chk(name, data_out, target);
    endtask

    task automatic run_until_done(input logic trg, input int max, input string name);
        int i = 0;
        while (done !== 1'b1 && i < max) begin
            step(trg, 1'b0, 1'b0);
            i++;
        end
        chk(name, done, 1);
    endtask

    initial begin
        int ff;
        int h_exp;
        int s;

        vecs[0]  = '{1'b0, 1'b0, 20, 8'h00, 1'b0, 1'b0};
        vecs[1]  = '{1'b1, 1'b0, 1,  8'h00, 1'b1, 1'b0};
        vecs[2]  = '{1'b0, 1'b0, 3,  8'h00, 1'b1, 1'b0};
        vecs[3]  = '{1'b0, 1'b0, 1,  8'h01, 1'b1, 1'b0};
        vecs[4]  = '{1'b0, 1'b0, 4,  8'h03, 1'b1, 1'b0};
        vecs[5]  = '{1'b0, 1'b0, 4,  8'h07, 1'b1, 1'b0};
        vecs[6]  = '{1'b0, 1'b0, 4,  8'h0F, 1'b1, 1'b0};
        vecs[7]  = '{1'b0, 1'b0, 4,  8'h1F, 1'b1, 1'b0};
        vecs[8]  = '{1'b0, 1'b0, 4,  8'h3F, 1'b1, 1'b0};
        vecs[9]  = '{1'b0, 1'b0, 4,  8'h7F, 1'b1, 1'b0};
        vecs[10] = '{1'b0, 1'b0, 4,  8'hFF, 1'b1, 1'b0};

        #1 rst = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("rst_data", data_out, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_react_time", react_time, 0);
        chk("rst_react_valid", react_valid, 0);
        rst  = 1'b1;
        ncyc = 0;

        // Idle, one-cycle trigger at cycle 20, lamps at 4-cycle spacing.
        for (int v = 0; v < 11; v++) begin
            for (int k = 0; k < vecs[v].n; k++) step(vecs[v].trg, vecs[v].abt, 1'b0);
            chk("vec_data", data_out, vecs[v].d);
            chk("vec_busy", busy, vecs[v].b);
            chk("vec_done", done, vecs[v].dn);
        end

        // Hold length from the LFSR value in the filling tick cycle (cycle 52).
        h_exp = lfsr_at(20 + 8 * T) + MINH;
        ff = 1;
        for (int i = 0; i < 1000 && data_out == 8'hFF; i++) begin
            step(1'b0, 1'b0, 1'b0);
            if (data_out == 8'hFF) ff++;
        end
        chk("hold_len", ff, h_exp * T);
        chk("end_data", data_out, 0);
        chk("end_done", done, 1);
        chk("end_busy", busy, 0);
        step(1'b0, 1'b0, 1'b0);
        chk("done_width", done, 0);

`ifdef F1_REACTION_TIMER_EN
        for (int i = 0; i < 36; i++) step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1);
        chk("react_valid_37", react_valid, 1);
        chk("react_time_37", react_time, 37);
        step(1'b0, 1'b0, 1'b0);
        chk("react_valid_pulse", react_valid, 0);
        chk("react_time_hold", react_time, 37);
`endif

        // Abort at 8'h07, then restart two cycles later.
        step(1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        run_until_data(1'b0, 8'h07, 100, "reach_07");
        step(1'b0, 1'b1, 1'b0);
        chk("abort_data", data_out, 0);
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        step(1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        chk("restart_busy", busy, 1);
        run_until_data(1'b0, 8'h01, 50, "restart_01");

        // Trigger held high through two sequences.
        run_until_done(1'b1, 700, "held_done1");
        chk("held_busy_low", busy, 0);
        step(1'b1, 1'b0, 1'b0);
        chk("held_restart_busy", busy, 1);
        chk("held_restart_data", data_out, 0);
        run_until_done(1'b1, 700, "held_done2");
        step(1'b0, 1'b0, 1'b0);

`ifdef F1_REACTION_TIMER_EN
        step(1'b1, 1'b0, 1'b0);
        run_until_data(1'b0, 8'hFF, 100, "jump_reach_ff");
        step(1'b0, 1'b0, 1'b1);
        run_until_done(1'b0, 700, "jump_done");
        chk("jump_valid", react_valid, 1);
        chk("jump_time", react_time, 16'hFFFF);
        step(1'b0, 1'b0, 1'b0);
`endif

        // Async reset during HOLD, then LFSR restart.
        step(1'b1, 1'b0, 1'b0);
        run_until_data(1'b0, 8'hFF, 100, "reach_hold");
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        #3 rst = 1'b0;
        #1;
        chk("async_data", data_out, 0);
        chk("async_busy", busy, 0);
        chk("async_done", done, 0);
        @(posedge clk);
        #1;
        rst      = 1'b1;
        ncyc     = 0;
        m_active = 1'b0;
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b0);
        s = ncyc;
        step(1'b1, 1'b0, 1'b0);
        run_until_done(1'b0, 700, "post_reset_done");
        chk("lfsr_restart", ncyc, s + 1 + 8 * T + (lfsr_at(s + 8 * T) + MINH) * T);

        // Random trigger/abort/react traffic against the model.
        for (int i = 0; i < 4000; i++) begin
            step(($urandom_range(0, 7) == 0), ($urandom_range(0, 299) == 0), 1'($urandom_range(0, 1)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/f1_light_sequencer.md
Name: f1_light_sequencer

Overview:
Controller for the F1 start-light strip. On a trigger it lights 8 lamps one per tick, holds all 8 on for a pseudo-random number of ticks, then extinguishes them and pulses done. It sits between the user input (button/vbd trigger) and the lamp display. It owns the step timing, the random hold delay and the abort handling.

Parameters:
TICK_CYCLES, 24, clk cycles per light step (>=2)
LFSR_WIDTH, 7, width of the random-delay LFSR (fixed polynomial below assumes 7)
MIN_HOLD_TICKS, 1, constant added to the LFSR value to form the hold length; MIN_HOLD_TICKS + 2^LFSR_WIDTH - 1 must be <= 255

Ports:
clk  in  1  system clock, all logic on posedge
rst  in  1  asynchronous, active-low reset (0 = reset)
trigger  in  1  level, sampled each clk; starts a sequence when IDLE
abort  in  1  level; cancels an active sequence
data_out  out  [8:1]  lamp drive, bit 1 = first lamp
busy  out  1  high in any state except IDLE
done  out  1  one-cycle pulse in the cycle the lamps go dark after HOLD
react  in  1  reaction button (used only with F1_REACTION_TIMER_EN)
react_time  out  16  cycles from lamps-off to react
react_valid  out  1  one-cycle pulse when react_time updates

Behaviour:
- Reset (rst=0, async): state=IDLE, data_out=0, busy=0, done=0, tick counter=0, hold counter=0, LFSR=7'h01, react_time=0, react_valid=0.
- LFSR: Fibonacci x^7+x^6+1, next = {lfsr[5:0], lfsr[6]^lfsr[5]}. Advances every clk cycle out of reset, in every state. It is never zero. Period is 127.
- Tick counter: runs only outside IDLE. It is cleared to 0 on entry to COUNT and counts 0..TICK_CYCLES-1. tick=1 when count==TICK_CYCLES-1, then wraps to 0.
- States: IDLE, COUNT, HOLD. All outputs are registered.
- IDLE: data_out=0. When trigger=1 and abort=0: go to COUNT and set busy=1 next cycle. data_out stays 0.
- COUNT: on each tick, data_out <= {data_out[7:1],1'b1}. The first lamp lights TICK_CYCLES cycles after COUNT entry. On the tick that makes data_out=8'hFF: load hold counter = LFSR value in that cycle + MIN_HOLD_TICKS, then go to HOLD.
- HOLD: on each tick, the hold counter decrements. On the tick where the hold counter == 1: data_out <= 0, done <= 1 for one cycle, state <= IDLE, busy <= 0. The lamps therefore stay fully lit for exactly hold_value ticks.
- abort=1 in COUNT or HOLD: next cycle the state is IDLE, data_out=0, busy=0, and done is NOT pulsed. abort has priority over tick. abort in IDLE has priority over trigger (no start).
- trigger while busy is ignored; no queueing. If trigger is held high through done, a new sequence starts on the cycle after returning to IDLE.
- Async reset mid-sequence: immediate return to the reset values, no done pulse.

Optional Feature:
F1_REACTION_TIMER_EN
- Defined: a 16-bit cycle counter is cleared in the cycle done pulses and increments each cycle while armed, saturating at 16'hFFFF.
  - The first react=1 while armed latches the count into react_time, pulses react_valid and disarms the counter.
  - react during COUNT/HOLD (jump start) sets react_time=16'hFFFF and pulses react_valid at done.
  - A trigger start disarms the timer but keeps react_time.
- Not defined: react is ignored, react_time=0 and react_valid=0 constant, and no counter logic is generated.

Decomposition:
- Package f1_pkg holds:
  - the state enum typedef {IDLE, COUNT, HOLD}
  - the LFSR seed constant (7'h01)
  - the lamp-count constant NUM_LAMPS=8
- One natural sub-module, f1_lfsr: free-running, parameterised width, exposes the current value. The FSM, tick counter and hold counter stay in f1_light_sequencer.

Test Plan:
- Reset release, TICK_CYCLES=4, no trigger for 20 cycles -> data_out=0, busy=0, done never asserted.
- One-cycle trigger, TICK_CYCLES=4 -> data_out goes 01,03,07,...,FF at 4-cycle spacing. It stays FF for (captured LFSR + MIN_HOLD_TICKS)*4 cycles, checked against a bench LFSR model. It then goes to 00 with a single-cycle done, and busy drops in the same cycle.
- abort asserted when data_out=8'h07 -> next cycle data_out=0, busy=0, no done; a trigger 2 cycles later restarts from 8'h01.
- trigger held high continuously for two sequences -> second sequence begins the cycle after done; retriggers mid-sequence have no effect.
- rst pulled low during HOLD -> data_out=0, busy=0 immediately (async), and the LFSR restarts at 7'h01 after release.
- With F1_REACTION_TIMER_EN, react asserted 37 cycles after done -> react_time=37, react_valid for 1 cycle. react pressed in HOLD -> react_time=16'hFFFF at done.
